sramlike_write_buffer: RTL and testbench
========================================

SRAMLIKE_WRITE_BUFFER -- requirements
Module: sramlike_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writes; power of 2, 2..16.
REQ-002 SHALL have ports clk in 1 (sole clock) and rst in 1 (synchronous, active-high reset).
REQ-003 SHALL have upstream slave ports s_req in 1, s_wr in 1, s_size in 2, s_addr in 32, s_wdata in 32: CPU data sram-like request.
REQ-004 SHALL have upstream slave ports s_rdata out 32, s_addr_ok out 1, s_data_ok out 1: sram-like responses to CPU.
REQ-005 SHALL have downstream master ports m_req out 1, m_wr out 1, m_size out 2, m_addr out 32, m_wdata out 32: request to AXI bridge data port.
REQ-006 SHALL have downstream master ports m_rdata in 32, m_addr_ok in 1, m_data_ok in 1: AXI bridge responses.
REQ-007 SHALL have status output wb_empty out 1: high when no write is buffered and none is in flight.

Function
REQ-008 SHALL hold a FIFO of DEPTH entries {addr[31:0], size[1:0], wdata[31:0]}, with log2(DEPTH)+1-bit wrapping read and write pointers.
REQ-009 SHALL use FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, with exactly one downstream transaction outstanding at any time.
REQ-010 Upstream write: s_addr_ok=1 combinationally when s_req&s_wr, FIFO not full, and no read outstanding; push occurs on that edge.
REQ-011 Posted write: s_data_ok SHALL pulse exactly 1 cycle after write acceptance, with s_rdata=0.
REQ-012 Full: s_addr_ok=0 for writes; a pop in the same cycle SHALL NOT enable acceptance (full is the registered value).
REQ-013 Drain: IDLE with FIFO non-empty -> WR_ADDR; m_req=1, m_wr=1, m_addr/m_size/m_wdata = head entry.
REQ-014 WR_ADDR -> WR_RESP on m_addr_ok; m_req=0 in WR_RESP; WR_RESP -> IDLE on m_data_ok, popping the head on that edge.
REQ-015 Read acceptance: allowed only in IDLE with FIFO empty. s_addr_ok SHALL mirror m_addr_ok, with m_req=s_req, m_wr=0, and address/size passed through; FSM moves IDLE -> RD_RESP on the handshake.
REQ-016 Read pending: when FIFO is non-empty, s_addr_ok=0 for the read until drain completes; drain SHALL have priority over a waiting read.
REQ-017 RD_RESP: s_data_ok=m_data_ok and s_rdata=m_rdata combinationally; -> IDLE on m_data_ok. While RD_ADDR/RD_RESP, s_addr_ok=0 for all requests.
REQ-018 RD_ADDR SHALL be used only if m_addr_ok lags s_req; it holds m_req=1 with the latched read address until m_addr_ok.
REQ-019 Order: downstream writes SHALL issue in acceptance order; a read SHALL never overtake a buffered write.
REQ-020 Simultaneous push and pop SHALL keep the count unchanged and preserve order.
REQ-021 wb_empty = FIFO empty & state not in {WR_ADDR, WR_RESP}.
REQ-022 Unused m_* data outputs SHALL be 0 when m_req=0.

Reset
REQ-023 On rst: pointers=0, FSM=IDLE, and the pending posted-ack flag cleared. Outputs: s_addr_ok=0, s_data_ok=0, s_rdata=0, m_req=0, m_wr=0, m_addr=0, m_size=0, m_wdata=0, wb_empty=1.
REQ-024 Reset mid-operation SHALL discard buffered writes and any in-flight transaction, with no further s_data_ok.

Configuration
REQ-025 Macro WBUF_RAW_FWD_EN: when defined, a read whose s_addr matches the youngest buffered entry with size=2 and identical word address SHALL complete locally.
REQ-026 Local completion: s_addr_ok=1 on the request cycle, s_data_ok=1 the next cycle with that entry's wdata, and no downstream request.
REQ-027 Under WBUF_RAW_FWD_EN, a match against a partial-size entry, or against a non-youngest entry overlapping younger ones, SHALL fall back to REQ-016.
REQ-028 When WBUF_RAW_FWD_EN is undefined, all reads follow REQ-015/016 and no compare logic is synthesized.

Verification
REQ-029 Write 0x1000<=0xAAAA_5555 with m_addr_ok held 0 -> s_addr_ok same cycle, s_data_ok next cycle, m_req=1 with m_addr=0x1000.
REQ-030 Four writes with m_addr_ok=0 (DEPTH=4) -> 5th write has s_addr_ok=0 until the first m_data_ok, then is accepted.
REQ-031 Write 0x2000<=0x1234_5678, then read 0x3000 -> read s_addr_ok stays 0 until the write's m_data_ok; the read's m_req follows.
REQ-032 With WBUF_RAW_FWD_EN: write 0x2000<=0xDEAD_BEEF (size 2), read 0x2000 -> s_data_ok with s_rdata=0xDEAD_BEEF and no read m_req; without the macro -> drain, then downstream read.
REQ-033 Pulse rst while in WR_RESP with 3 entries buffered -> next cycle FSM=IDLE, wb_empty=1, m_req=0, and a later stray m_data_ok produces no s_data_ok.
REQ-034 Back-to-back writes 0x10, 0x14, 0x18 with random m_addr_ok/m_data_ok delays -> downstream order 0x10, 0x14, 0x18 and exactly 3 s_data_ok pulses.

Source files
------------

// File: rtl/sramlike_write_buffer.sv
// rtl/sramlike_write_buffer.sv - posted write buffer between a CPU sram-like data port and an AXI bridge
//
// Purpose:
//   Accepts CPU writes into a DEPTH-entry FIFO and acknowledges them one cycle
//   later (posted). Buffered writes drain to the bridge one at a time in
//   acceptance order. Reads wait until the buffer is empty and then pass
//   straight through to the bridge. Only one downstream transaction is ever
//   outstanding.
//
// Optional feature (macro WBUF_RAW_FWD_EN):
//   A read that hits the youngest buffered entry (full-word entry, same word
//   address) is answered locally from that entry's wdata with no downstream
//   request. With the macro undefined no compare logic exists.
//
// Ports:
//   clk, rst                      - sole clock, synchronous active-high reset
//   s_req/s_wr/s_size/s_addr/s_wdata - CPU request (sram-like slave side)
//   s_rdata/s_addr_ok/s_data_ok   - CPU responses
//   m_req/m_wr/m_size/m_addr/m_wdata - request to the AXI bridge data port
//   m_rdata/m_addr_ok/m_data_ok   - bridge responses
//   wb_empty                      - no write buffered and none in flight
module sramlike_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_req,
  input  logic        s_wr,
  input  logic [1:0]  s_size,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  output logic        s_addr_ok,
  output logic        s_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        wb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  // FIFO storage; entries are invalidated by pointer reset, so no data reset
  logic [31:0] addr_mem_q [DEPTH];
  logic [1:0]  size_mem_q [DEPTH];
  logic [31:0] data_mem_q [DEPTH];

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  state_t      state_q;
  state_t      state_d;
  logic        ack_pend_q;
  // A read was shown downstream last cycle without m_addr_ok
  logic        rd_exposed_q;
  logic [31:0] rd_addr_q;
  logic [1:0]  rd_size_q;

  logic          fifo_empty;
  logic          fifo_full;
  logic [AW-1:0] head_idx;
  logic          rd_busy;
  logic          wr_acc;
  logic          rd_pass;
  logic          pop;

  logic          fwd_acc;
  logic          fwd_pend;
  logic [31:0]   fwd_data;

  assign fifo_empty = (wptr_q == rptr_q);
  // Full uses registered pointers only: a pop this cycle does not open a slot
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_idx   = rptr_q[AW-1:0];

  assign rd_busy = (state_q == RD_ADDR) || (state_q == RD_RESP) || rd_exposed_q;
  assign wr_acc  = s_req && s_wr && !fifo_full && !rd_busy;
  // Reads pass through only once every buffered write has drained
  assign rd_pass = (state_q == IDLE) && fifo_empty && s_req && !s_wr;
  assign pop     = (state_q == WR_RESP) && m_data_ok;

`ifdef WBUF_RAW_FWD_EN
  logic [AW-1:0] young_idx;
  logic          fwd_hit;
  logic          fwd_pend_q;
  logic [31:0]   fwd_data_q;

  assign young_idx = wptr_q[AW-1:0] - AW'(1);
  // Only the youngest entry is compared, so no younger write can overlap it
  assign fwd_hit   = !fifo_empty &&
                     (size_mem_q[young_idx] == 2'd2) &&
                     (addr_mem_q[young_idx][31:2] == s_addr[31:2]);
  assign fwd_acc   = s_req && !s_wr && !rd_busy && fwd_hit;
  assign fwd_pend  = fwd_pend_q;
  assign fwd_data  = fwd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_pend_q <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_pend_q <= fwd_acc;
      if (fwd_acc) begin
        fwd_data_q <= data_mem_q[young_idx];
      end
    end
  end
`else
  assign fwd_acc  = 1'b0;
  assign fwd_pend = 1'b0;
  assign fwd_data = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      addr_mem_q[wptr_q[AW-1:0]] <= s_addr;
      size_mem_q[wptr_q[AW-1:0]] <= s_size;
      data_mem_q[wptr_q[AW-1:0]] <= s_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // Drain has priority over any waiting read
        if (!fifo_empty) begin
          state_d = WR_ADDR;
        end else if (rd_pass && m_addr_ok) begin
          state_d = RD_RESP;
        end else if (rd_exposed_q && !rd_pass) begin
          // CPU withdrew a read already presented downstream; keep it stable
          state_d = RD_ADDR;
        end
      end
      WR_ADDR: if (m_addr_ok) state_d = WR_RESP;
      WR_RESP: if (m_data_ok) state_d = IDLE;
      RD_ADDR: if (m_addr_ok) state_d = RD_RESP;
      RD_RESP: if (m_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      ack_pend_q   <= 1'b0;
      rd_exposed_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_size_q    <= '0;
    end else begin
      state_q      <= state_d;
      ack_pend_q   <= wr_acc;
      rd_exposed_q <= rd_pass && !m_addr_ok;
      if (wr_acc) begin
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      if (rd_pass) begin
        rd_addr_q <= s_addr;
        rd_size_q <= s_size;
      end
    end
  end

  always_comb begin
    s_addr_ok = wr_acc || fwd_acc || (rd_pass && m_addr_ok);
    s_data_ok = ack_pend_q || fwd_pend || ((state_q == RD_RESP) && m_data_ok);
    if (fwd_pend) begin
      s_rdata = fwd_data;
    end else if (state_q == RD_RESP) begin
      s_rdata = m_rdata;
    end else begin
      s_rdata = 32'h0;
    end
  end

  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    unique case (state_q)
      WR_ADDR: begin
        m_req   = 1'b1;
        m_wr    = 1'b1;
        m_size  = size_mem_q[head_idx];
        m_addr  = addr_mem_q[head_idx];
        m_wdata = data_mem_q[head_idx];
      end
      RD_ADDR: begin
        m_req  = 1'b1;
        m_size = rd_size_q;
        m_addr = rd_addr_q;
      end
      IDLE: begin
        if (rd_pass) begin
          m_req  = 1'b1;
          m_size = s_size;
          m_addr = s_addr;
        end
      end
      default: begin
      end
    endcase
  end

  assign wb_empty = fifo_empty && (state_q != WR_ADDR) && (state_q != WR_RESP);

endmodule

// File: tb/tb_sramlike_write_buffer.sv
// tb/tb_sramlike_write_buffer.sv - directed self-checking bench for sramlike_write_buffer
module tb_sramlike_write_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata;
  logic        s_addr_ok, s_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
  logic        m_addr_ok, m_data_ok;
  logic        wb_empty;

  int checks = 0;
  int errors = 0;
  int dok_cnt = 0;
  int rd_req_cnt = 0;
  logic [31:0] wr_log [$];

  sramlike_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .wb_empty(wb_empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_data_ok === 1'b1) dok_cnt++;
    if (m_req === 1'b1 && m_wr === 1'b0) rd_req_cnt++;
    if (m_req === 1'b1 && m_wr === 1'b1 && m_addr_ok === 1'b1) wr_log.push_back(m_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    s_req = 1'b1; s_wr = 1'b1; s_size = 2'd2; s_addr = a; s_wdata = d;
  endtask

  task automatic drain_one(input logic [31:0] ea, input logic [31:0] ed, input int ad, input int dd);
    int n;
    n = 0;
    while (!(m_req === 1'b1 && m_wr === 1'b1) && n < 20) begin
      cyc(); #1; n++;
    end
    checks++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata} !== {1'b1, 1'b1, 2'd2, ea, ed}) begin
      errors++;
      $display("FAIL drain_head: got req=%b wr=%b size=%0d addr=%h data=%h, expected req=1 wr=1 size=2 addr=%h data=%h",
               m_req, m_wr, m_size, m_addr, m_wdata, ea, ed);
    end
    repeat (ad) begin cyc(); #1; end
    m_addr_ok = 1'b1; #1;
    cyc(); m_addr_ok = 1'b0;
    repeat (dd) cyc();
    m_data_ok = 1'b1;
    cyc(); m_data_ok = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_req = 0; s_wr = 0; s_size = 0; s_addr = 0; s_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
    cyc(); cyc(); rst = 1'b0; #1;
    checks++;
    if ({s_addr_ok, s_data_ok, s_rdata} !== 34'h0) begin
      errors++; $display("FAIL reset_s_outputs: got %b %b %h, expected 0 0 00000000", s_addr_ok, s_data_ok, s_rdata);
    end
    checks++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_m_outputs: got req=%b wr=%b size=%0d addr=%h data=%h, expected all 0", m_req, m_wr, m_size, m_addr, m_wdata);
    end
    checks++;
    if (wb_empty !== 1'b1) begin
      errors++; $display("FAIL reset_wb_empty: got %b expected 1", wb_empty);
    end
  endtask

  task automatic test_single_write();
    cpu_write(32'h1000, 32'hAAAA_5555); #1;
    checks++;
    if ({s_addr_ok, s_data_ok} !== 2'b10) begin
      errors++; $display("FAIL wr_accept: got addr_ok=%b data_ok=%b expected 1 0", s_addr_ok, s_data_ok);
    end
    cyc(); s_req = 1'b0; #1;
    checks++;
    if ({s_data_ok, s_rdata, m_req, wb_empty} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL wr_posted_ack: got data_ok=%b rdata=%h m_req=%b wb_empty=%b expected 1 00000000 0 0", s_data_ok, s_rdata, m_req, wb_empty);
    end
    cyc(); #1;
    checks++;
    if ({s_data_ok, m_req, m_wr, m_size, m_addr, m_wdata} !== {1'b0, 1'b1, 1'b1, 2'd2, 32'h1000, 32'hAAAA_5555}) begin
      errors++; $display("FAIL wr_issue: got data_ok=%b req=%b wr=%b size=%0d addr=%h data=%h expected 0 1 1 2 00001000 aaaa5555", s_data_ok, m_req, m_wr, m_size, m_addr, m_wdata);
    end
    cyc(); #1;
    checks++;
    if ({m_req, m_addr} !== {1'b1, 32'h1000}) begin
      errors++; $display("FAIL wr_hold: got req=%b addr=%h expected 1 00001000", m_req, m_addr);
    end
    m_addr_ok = 1'b1; #1;
    cyc(); m_addr_ok = 1'b0; #1;
    checks++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata, wb_empty} !== 69'h0) begin
      errors++; $display("FAIL wr_resp_idle_bus: got req=%b wr=%b size=%0d addr=%h data=%h wb_empty=%b expected all 0", m_req, m_wr, m_size, m_addr, m_wdata, wb_empty);
    end
    m_data_ok = 1'b1; #1;
    cyc(); m_data_ok = 1'b0; #1;
    checks++;
    if ({wb_empty, m_req, s_data_ok} !== 3'b100) begin
      errors++; $display("FAIL wr_done: got wb_empty=%b m_req=%b data_ok=%b expected 1 0 0", wb_empty, m_req, s_data_ok);
    end
  endtask

  task automatic test_full();
    int base;
    logic [31:0] exp_a [5];
    base = wr_log.size();
    exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C; exp_a[4] = 32'h200;
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'h100 + 4 * i, 32'h1111_0000 + i); #1;
      checks++;
      if (s_addr_ok !== 1'b1) begin
        errors++; $display("FAIL fill_accept%0d: got %b expected 1", i, s_addr_ok);
      end
      cyc();
    end
    cpu_write(32'h200, 32'h2222_0000); #1;
    checks++;
    if (s_addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_block: got %b expected 0", s_addr_ok);
    end
    cyc(); cyc(); #1;
    checks++;
    if ({s_addr_ok, m_req, m_addr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++; $display("FAIL full_hold: got addr_ok=%b m_req=%b m_addr=%h expected 0 1 00000100", s_addr_ok, m_req, m_addr);
    end
    m_addr_ok = 1'b1; #1;
    cyc(); m_addr_ok = 1'b0; #1;
    m_data_ok = 1'b1; #1;
    checks++;
    if (s_addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_pop_same_cycle: got %b expected 0", s_addr_ok);
    end
    cyc(); m_data_ok = 1'b0; #1;
    checks++;
    if (s_addr_ok !== 1'b1) begin
      errors++; $display("FAIL accept_after_pop: got %b expected 1", s_addr_ok);
    end
    cyc(); s_req = 1'b0; #1;
    drain_one(32'h104, 32'h1111_0001, 0, 0);
    drain_one(32'h108, 32'h1111_0002, 1, 0);
    drain_one(32'h10C, 32'h1111_0003, 0, 2);
    drain_one(32'h200, 32'h2222_0000, 0, 0);
    checks++;
    if (wr_log.size() - base !== 5) begin
      errors++; $display("FAIL full_order_count: got %0d expected 5", wr_log.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_log[base + i] !== exp_a[i]) begin
          errors++; $display("FAIL full_order%0d: got %h expected %h", i, wr_log[base + i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_read_after_write();
    cpu_write(32'h2000, 32'h1234_5678); #1;
    checks++;
    if (s_addr_ok !== 1'b1) begin
      errors++; $display("FAIL raw_wr_accept: got %b expected 1", s_addr_ok);
    end
    cyc();
    s_wr = 1'b0; s_addr = 32'h3000; s_size = 2'd2; #1;
    checks++;
    if ({s_addr_ok, s_data_ok, m_req} !== 3'b010) begin
      errors++; $display("FAIL rd_wait0: got addr_ok=%b data_ok=%b m_req=%b expected 0 1 0", s_addr_ok, s_data_ok, m_req);
    end
    cyc(); #1;
    m_addr_ok = 1'b1; #1;
    checks++;
    if ({s_addr_ok, m_req, m_wr, m_addr} !== {1'b0, 1'b1, 1'b1, 32'h2000}) begin
      errors++; $display("FAIL rd_wait_drain: got addr_ok=%b req=%b wr=%b addr=%h expected 0 1 1 00002000", s_addr_ok, m_req, m_wr, m_addr);
    end
    cyc(); m_addr_ok = 1'b0; #1;
    m_data_ok = 1'b1; #1;
    checks++;
    if ({s_addr_ok, m_req} !== 2'b00) begin
      errors++; $display("FAIL rd_wait_resp: got addr_ok=%b m_req=%b expected 0 0", s_addr_ok, m_req);
    end
    cyc(); m_data_ok = 1'b0; #1;
    checks++;
    if ({s_addr_ok, m_req, m_wr, m_size, m_addr, m_wdata} !== {1'b0, 1'b1, 1'b0, 2'd2, 32'h3000, 32'h0}) begin
      errors++; $display("FAIL rd_issue: got addr_ok=%b req=%b wr=%b size=%0d addr=%h data=%h expected 0 1 0 2 00003000 00000000", s_addr_ok, m_req, m_wr, m_size, m_addr, m_wdata);
    end
    m_addr_ok = 1'b1; #1;
    checks++;
    if (s_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rd_mirror: got %b expected 1", s_addr_ok);
    end
    cyc(); m_addr_ok = 1'b0;
    cpu_write(32'h500, 32'h5); #1;
    checks++;
    if ({s_addr_ok, m_req, s_data_ok} !== 3'b000) begin
      errors++; $display("FAIL rd_resp_block: got addr_ok=%b m_req=%b data_ok=%b expected 0 0 0", s_addr_ok, m_req, s_data_ok);
    end
    s_req = 1'b0; m_rdata = 32'hCAFE_F00D; m_data_ok = 1'b1; #1;
    checks++;
    if ({s_data_ok, s_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL rd_data: got data_ok=%b rdata=%h expected 1 cafef00d", s_data_ok, s_rdata);
    end
    cyc(); m_data_ok = 1'b0; m_rdata = 32'h0; #1;
    checks++;
    if ({s_data_ok, wb_empty, m_req} !== 3'b010) begin
      errors++; $display("FAIL rd_done: got data_ok=%b wb_empty=%b m_req=%b expected 0 1 0", s_data_ok, wb_empty, m_req);
    end
  endtask

  task automatic test_raw_fwd();
    int base_rd;
    base_rd = rd_req_cnt;
    cpu_write(32'h2000, 32'hDEAD_BEEF); #1;
    cyc();
    s_wr = 1'b0; #1;
`ifdef WBUF_RAW_FWD_EN
    checks++;
    if ({s_addr_ok, m_req} !== 2'b10) begin
      errors++; $display("FAIL fwd_accept: got addr_ok=%b m_req=%b expected 1 0", s_addr_ok, m_req);
    end
    cyc(); s_req = 1'b0; #1;
    checks++;
    if ({s_data_ok, s_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL fwd_data: got data_ok=%b rdata=%h expected 1 deadbeef", s_data_ok, s_rdata);
    end
    drain_one(32'h2000, 32'hDEAD_BEEF, 1, 1);
    cyc(); #1;
    checks++;
    if (rd_req_cnt - base_rd !== 0) begin
      errors++; $display("FAIL fwd_no_read_req: got %0d read request cycles expected 0", rd_req_cnt - base_rd);
    end
`else
    checks++;
    if (s_addr_ok !== 1'b0) begin
      errors++; $display("FAIL nofwd_wait: got %b expected 0", s_addr_ok);
    end
    drain_one(32'h2000, 32'hDEAD_BEEF, 1, 1);
    checks++;
    if ({s_addr_ok, m_req, m_wr, m_addr} !== {1'b0, 1'b1, 1'b0, 32'h2000}) begin
      errors++; $display("FAIL nofwd_read_issue: got addr_ok=%b req=%b wr=%b addr=%h expected 0 1 0 00002000", s_addr_ok, m_req, m_wr, m_addr);
    end
    m_addr_ok = 1'b1; #1;
    cyc(); s_req = 1'b0; m_addr_ok = 1'b0; m_rdata = 32'hDEAD_BEEF; m_data_ok = 1'b1; #1;
    checks++;
    if ({s_data_ok, s_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL nofwd_read_data: got data_ok=%b rdata=%h expected 1 deadbeef", s_data_ok, s_rdata);
    end
    cyc(); m_data_ok = 1'b0; m_rdata = 32'h0; #1;
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    for (int i = 0; i < 3; i++) begin
      cpu_write(32'h40 + 4 * i, 32'h3333_0000 + i); #1;
      cyc();
    end
    s_req = 1'b0;
    m_addr_ok = 1'b1; #1;
    cyc(); m_addr_ok = 1'b0; #1;
    checks++;
    if ({m_req, wb_empty} !== 2'b00) begin
      errors++; $display("FAIL mid_pre: got m_req=%b wb_empty=%b expected 0 0", m_req, wb_empty);
    end
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    base = dok_cnt;
    checks++;
    if ({wb_empty, m_req, s_data_ok} !== 3'b100) begin
      errors++; $display("FAIL mid_reset: got wb_empty=%b m_req=%b data_ok=%b expected 1 0 0", wb_empty, m_req, s_data_ok);
    end
    m_data_ok = 1'b1;
    cyc(); m_data_ok = 1'b0;
    cyc(); cyc(); #1;
    checks++;
    if ({dok_cnt - base, m_req, wb_empty} !== {32'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mid_stray: got data_ok pulses=%0d m_req=%b wb_empty=%b expected 0 0 1", dok_cnt - base, m_req, wb_empty);
    end
  endtask

  task automatic test_back_to_back();
    int base_log;
    int base_dok;
    base_log = wr_log.size();
    base_dok = dok_cnt;
    for (int i = 0; i < 3; i++) begin
      cpu_write(32'h10 + 4 * i, 32'hB0 + i); #1;
      checks++;
      if (s_addr_ok !== 1'b1) begin
        errors++; $display("FAIL b2b_accept%0d: got %b expected 1", i, s_addr_ok);
      end
      cyc();
    end
    s_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drain_one(32'h10 + 4 * i, 32'hB0 + i, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    cyc(); cyc(); #1;
    checks++;
    if (dok_cnt - base_dok !== 3) begin
      errors++; $display("FAIL b2b_ack_count: got %0d expected 3", dok_cnt - base_dok);
    end
    checks++;
    if (wr_log.size() - base_log !== 3) begin
      errors++; $display("FAIL b2b_issue_count: got %0d expected 3", wr_log.size() - base_log);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_log[base_log + i] !== 32'h10 + 4 * i) begin
          errors++; $display("FAIL b2b_order%0d: got %h expected %h", i, wr_log[base_log + i], 32'h10 + 4 * i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_read_after_write();
    test_raw_fwd();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
